// File: rtl/gpio_wb_arbiter_if.sv
// Bus bundle between the GPIO register-port arbiter, its requesters and the GPIO slave.
// The "master" modport is the arbiter's view; "slave" is the view of everything around it.
interface gpio_wb_arbiter_if #(
    parameter int N_MASTERS = 2
);
    // A requester raises m_cyc[i] with m_we/m_adr/m_dat stable and holds it until its own
    // one-cycle m_ack[i] or m_err[i]; the arbiter holds s_cyc until s_ack or an abort/timeout.
    logic [N_MASTERS-1:0]   m_cyc;
    logic [N_MASTERS-1:0]   m_we;
    logic [2*N_MASTERS-1:0] m_adr;
    logic [8*N_MASTERS-1:0] m_dat;
    logic [7:0]             m_rdt;
    logic [N_MASTERS-1:0]   m_ack;
    logic [N_MASTERS-1:0]   m_err;
    logic [N_MASTERS-1:0]   grant;
    logic                   s_cyc;
    logic                   s_we;
    logic [1:0]             s_adr;
    logic [7:0]             s_dat;
    logic [7:0]             s_rdt;
    logic                   s_ack;

    modport master (
        input  m_cyc, m_we, m_adr, m_dat, s_rdt, s_ack,
        output m_rdt, m_ack, m_err, grant, s_cyc, s_we, s_adr, s_dat
    );

    modport slave (
        output m_cyc, m_we, m_adr, m_dat, s_rdt, s_ack,
        input  m_rdt, m_ack, m_err, grant, s_cyc, s_we, s_adr, s_dat
    );
endinterface

// File: rtl/gpio_wb_arbiter.sv
// Round-robin arbiter sharing one 8-bit GPIO register port between N_MASTERS requesters.
// Optional busy timeout with m_err reporting is enabled by defining GPIO_ARB_TIMEOUT_EN.
module gpio_wb_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              rst,
    gpio_wb_arbiter_if.master bus,
    output logic [1:0]        dbg_state
);
    localparam int LW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [LW-1:0]        last_q, last_d;
    logic [LW-1:0]        pick, cand;
    logic                 pick_vld;
    logic                 own_cyc;
    logic                 tmo;

    // Search upward from the last owner so every requester gets a turn.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            cand = LW'((int'(last_q) + k) % N_MASTERS);
            if (!pick_vld && bus.m_cyc[cand]) begin
                pick_vld = 1'b1;
                pick     = cand;
            end
        end
    end

    // grant_q is one-hot only in BUSY, so this mux also zeroes the slave side elsewhere.
    always_comb begin
        bus.s_we  = 1'b0;
        bus.s_adr = '0;
        bus.s_dat = '0;
        own_cyc   = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant_q[i]) begin
                bus.s_we  = bus.m_we[i];
                bus.s_adr = bus.m_adr[2*i +: 2];
                bus.s_dat = bus.m_dat[8*i +: 8];
                own_cyc   = bus.m_cyc[i];
            end
        end
    end

`ifdef GPIO_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q != BUSY) begin
            cnt_d = '0;
        end else if (!bus.s_ack) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Fires on the BUSY cycle whose increment would bring the count to TIMEOUT; ack wins.
    assign tmo = (state_q == BUSY) && !bus.s_ack && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = BUSY;
                    grant_d = N_MASTERS'(1) << pick;
                    last_d  = pick;
                end
            end
            BUSY: begin
                if (bus.s_ack || !own_cyc || tmo) begin
                    state_d = DONE;
                    grant_d = '0;
                end
            end
            DONE: begin
                // Idle gap lets the slave's ack register fall before the next s_cyc.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LW'(N_MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign bus.s_cyc = (state_q == BUSY);
    assign bus.m_ack = (state_q == BUSY && bus.s_ack) ? grant_q : '0;
    assign bus.m_err = tmo ? grant_q : '0;
    assign bus.m_rdt = bus.s_rdt;
    assign bus.grant = grant_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_gpio_wb_arbiter.sv
// Bench for gpio_wb_arbiter: directed scenarios plus random traffic against a
// transaction-timeline reference model (each granted transfer spans 4 cycles).
module tb_gpio_wb_arbiter;
  localparam int N   = 2;
  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  logic       stall = 1'b0;
  logic       slv_ack = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;

  gpio_wb_arbiter_if #(.N_MASTERS(N)) bus ();

  gpio_wb_arbiter #(.N_MASTERS(N), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / slave model: registered ack one cycle after s_cyc, never reset
  always #5 clk = ~clk;
  always @(posedge clk) slv_ack <= bus.s_cyc & ~slv_ack & ~stall;
  assign bus.s_ack = slv_ack;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.m_cyc = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] req);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return 0;
  endfunction

  logic [N-1:0] exp_q[$];
  logic [N-1:0] exp_g, exp_a, ack_seen;
  logic         r_we[N];
  logic [1:0]   r_adr[N];
  logic [7:0]   r_dat[N];
  logic [7:0]   rdt;
  logic         prev_scyc, in_busy, ok_hi;
  int           free_at, bs, owner, last_m, pct, busy_cnt, err_at;

  initial begin
    bus.m_cyc = '0; bus.m_we = '0; bus.m_adr = '0; bus.m_dat = '0; bus.s_rdt = '0;
    for (int i = 0; i < N; i++) begin r_we[i] = 1'b0; r_adr[i] = '0; r_dat[i] = '0; end

    // reset state
    do_reset();
    smp();
    check("rst_grant", bus.grant, 0);
    check("rst_scyc", bus.s_cyc, 0);
    check("rst_ack", bus.m_ack, 0);
    check("rst_err", bus.m_err, 0);
    check("rst_sadr", bus.s_adr, 0);

    // single write from master 0
    step();
    bus.m_cyc = 2'b01; bus.m_we = 2'b01; bus.m_adr = 4'b0010; bus.m_dat = 16'h00F0;
    smp(); check("wr_c0_scyc", bus.s_cyc, 0);
    step(); smp();
    check("wr_c1_scyc", bus.s_cyc, 1);
    check("wr_c1_sadr", bus.s_adr, 2'b10);
    check("wr_c1_sdat", bus.s_dat, 8'hF0);
    check("wr_c1_swe", bus.s_we, 1);
    check("wr_c1_grant", bus.grant, 2'b01);
    check("wr_c1_ack", bus.m_ack, 0);
    step(); smp();
    check("wr_c2_ack", bus.m_ack, 2'b01);
    step(); bus.m_cyc = '0; smp();
    check("wr_c3_scyc", bus.s_cyc, 0);
    check("wr_c3_grant", bus.grant, 0);
    step();

    // read from master 1
    bus.m_cyc = 2'b10; bus.m_we = 2'b00; bus.m_adr = 4'b0100; bus.m_dat = 16'hAA00;
    bus.s_rdt = 8'h5A;
    smp(); step(); smp();
    check("rd_c1_grant", bus.grant, 2'b10);
    check("rd_c1_swe", bus.s_we, 0);
    check("rd_c1_sadr", bus.s_adr, 2'b01);
    step(); smp();
    check("rd_c2_ack", bus.m_ack, 2'b10);
    check("rd_c2_rdt", bus.m_rdt, 8'h5A);
    step(); bus.m_cyc = '0; smp(); step();

    // contention: both hold m_cyc for four transfers
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    bus.m_cyc = 2'b11;
    prev_scyc = 1'b0;
    for (int c = 0; c < 16; c++) begin
      smp();
      if (bus.s_cyc && !prev_scyc) begin
        if (exp_q.size() != 0) check("ctn_grant", bus.grant, exp_q.pop_front());
        else check("ctn_extra_grant", bus.grant, 0);
      end
      if (bus.m_ack != 0) begin
        check("ctn_ack_owner", bus.m_ack, bus.grant);
        check("ctn_ack_onehot", $countones(bus.m_ack), 1);
      end
      prev_scyc = bus.s_cyc;
      step();
    end
    bus.m_cyc = '0;
    check("ctn_all_served", exp_q.size(), 0);

    // abort: master 0 drops while slave stalls, master 1 served next
    stall = 1'b1; bus.m_cyc = 2'b11;
    smp(); step(); smp();
    check("abt_c1_grant", bus.grant, 2'b01);
    step(); bus.m_cyc = 2'b10; smp();
    check("abt_c2_ack", bus.m_ack, 0);
    step(); smp();
    check("abt_c3_scyc", bus.s_cyc, 0);
    check("abt_c3_grant", bus.grant, 0);
    check("abt_c3_ack", bus.m_ack, 0);
    step(); smp();
    check("abt_c4_grant", bus.grant, 0);
    step(); stall = 1'b0; smp();
    check("abt_c5_grant", bus.grant, 2'b10);
    step(); smp();
    check("abt_c6_ack", bus.m_ack, 2'b10);
    step(); bus.m_cyc = '0; smp(); step();

`ifdef GPIO_ARB_TIMEOUT_EN
    // timeout: slave never acks
    stall = 1'b1; bus.m_cyc = 2'b01; busy_cnt = 0; err_at = 0;
    for (int c = 0; c < 40 && err_at == 0; c++) begin
      smp();
      if (bus.s_cyc) busy_cnt++;
      if (bus.m_err != 0) begin
        err_at = busy_cnt;
        check("tmo_err_vec", bus.m_err, 2'b01);
        check("tmo_no_ack", bus.m_ack, 0);
      end
      step();
    end
    smp();
    check("tmo_busy_cycles", err_at, TMO);
    check("tmo_scyc_drop", bus.s_cyc, 0);
    step(); bus.m_cyc = '0; stall = 1'b0; step(); step();
`else
    // no timeout: slave never acks, s_cyc held until the master gives up
    stall = 1'b1; bus.m_cyc = 2'b01; ok_hi = 1'b1;
    for (int c = 0; c < 120; c++) begin
      smp();
      if (c >= 1 && (!bus.s_cyc || bus.m_err != 0)) ok_hi = 1'b0;
      step();
    end
    smp();
    check("notmo_held", ok_hi, 1);
    check("notmo_scyc", bus.s_cyc, 1);
    bus.m_cyc = '0;
    step(); smp();
    check("notmo_abort", bus.s_cyc, 0);
    stall = 1'b0; step(); step();
`endif

    // reset in cycle 1 of a transfer
    bus.m_cyc = 2'b10;
    smp(); step(); smp();
    check("rstm_c1_grant", bus.grant, 2'b10);
    rst = 1'b1;
    step(); smp();
    check("rstm_scyc", bus.s_cyc, 0);
    check("rstm_grant", bus.grant, 0);
    check("rstm_ack", bus.m_ack, 0);
    step(); rst = 1'b0; bus.m_cyc = 2'b11; smp();
    check("rstm_idle_grant", bus.grant, 0);
    step(); smp();
    check("rstm_first_grant", bus.grant, 2'b01);
    bus.m_cyc = '0;

    // random traffic against the timeline model
    do_reset();
    free_at = 0; bs = -10; owner = 0; last_m = N - 1; ack_seen = '0;
    for (int c = 0; c < 2000; c++) begin
      pct = (c < 700) ? 35 : (c < 1400) ? 100 : 60;
      for (int i = 0; i < N; i++) begin
        if (ack_seen[i]) begin
          bus.m_cyc[i] = 1'b0;
        end else if (!bus.m_cyc[i] && $urandom_range(0, 99) < pct) begin
          r_we[i]  = 1'($urandom_range(0, 1));
          r_adr[i] = 2'($urandom_range(0, 3));
          r_dat[i] = 8'($urandom_range(0, 255));
          bus.m_we[i] = r_we[i];
          bus.m_adr[2*i +: 2] = r_adr[i];
          bus.m_dat[8*i +: 8] = r_dat[i];
          bus.m_cyc[i] = 1'b1;
        end
      end
      rdt = 8'($urandom);
      bus.s_rdt = rdt;
      smp();
      in_busy = (c == bs) || (c == bs + 1);
      exp_g = in_busy ? (N'(1) << owner) : '0;
      exp_a = (c == bs + 1) ? exp_g : '0;
      check("rnd_grant", bus.grant, exp_g);
      check("rnd_scyc", bus.s_cyc, in_busy);
      check("rnd_swe", bus.s_we, in_busy ? r_we[owner] : 1'b0);
      check("rnd_sadr", bus.s_adr, in_busy ? r_adr[owner] : 2'b00);
      check("rnd_sdat", bus.s_dat, in_busy ? r_dat[owner] : 8'h00);
      check("rnd_ack", bus.m_ack, exp_a);
      check("rnd_err", bus.m_err, 0);
      if (exp_a != 0) check("rnd_rdt", bus.m_rdt, rdt);
      ack_seen = bus.m_ack;
      if (c >= free_at && bus.m_cyc != 0) begin
        owner   = rr_pick(last_m, bus.m_cyc);
        last_m  = owner;
        bs      = c + 1;
        free_at = c + 4;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
